// File: rtl/riscv_md_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit: funct3 op codes,
// FSM state encoding and the most-negative-value helper.
package riscv_md_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Callers truncate to XLEN; covers any XLEN up to 64.
  function automatic logic [63:0] md_most_neg(input int xlen);
    return 64'(1) << (xlen - 1);
  endfunction

endpackage

// File: rtl/riscv_md_special_detect.sv
// Combinational detection of operand cases whose result is fixed without
// iterating: divide by zero, signed overflow, zero multiply operand, rs2 == 1.
module riscv_md_special_detect
  import riscv_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            div_zero,
  output logic            overflow,
  output logic            mul_zero,
  output logic            one_case
);

  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(md_most_neg(XLEN));

  logic is_div;
  assign is_div = op[2];

  assign div_zero = is_div && (rs2 == '0);
  assign overflow = ((op == MD_DIV) || (op == MD_REM)) && (rs1 == MOST_NEG) && (rs2 == '1);
  assign mul_zero = !is_div && ((rs1 == '0) || (rs2 == '0));
  assign one_case = ((op == MD_MUL) || (op == MD_DIVU) || (op == MD_REMU)) && (rs2 == XLEN'(1));

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative MUL/DIV unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional early termination of trivial operands with `define MULDIV_FASTPATH_EN.
module riscv_muldiv_unit
  import riscv_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            MD_start,
  input  logic [2:0]      MD_op,
  input  logic [XLEN-1:0] MD_rs1_data,
  input  logic [XLEN-1:0] MD_rs2_data,
  input  logic            MD_flush,
  output logic            MD_busy,
  output logic            MD_done,
  output logic [XLEN-1:0] MD_result
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, mag_a, mag_b;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              fast_pend;

  // Handshake: a start is taken only on a cycle where MD_busy is low and
  // MD_flush is low; MD_done pulses for one cycle with MD_result valid.
  logic accept, last_step, fast_in;
  assign MD_busy   = (state != ST_IDLE);
  assign accept    = MD_start && (state == ST_IDLE) && !MD_flush;
  assign last_step = (cnt == CW'(XLEN - 1));

  logic            in_sa, in_sb;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  assign in_sa    = MD_rs1_data[XLEN-1] &&
                    (MD_op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign in_sb    = MD_rs2_data[XLEN-1] && (MD_op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
  assign in_mag_a = in_sa ? -MD_rs1_data : MD_rs1_data;
  assign in_mag_b = in_sb ? -MD_rs2_data : MD_rs2_data;

  logic q_div_zero, q_overflow, q_mul_zero, q_one_case;
  riscv_md_special_detect #(.XLEN(XLEN)) u_detect_q (
    .op       (op_q),
    .rs1      (rs1_q),
    .rs2      (rs2_q),
    .div_zero (q_div_zero),
    .overflow (q_overflow),
    .mul_zero (q_mul_zero),
    .one_case (q_one_case)
  );

`ifdef MULDIV_FASTPATH_EN
  logic i_div_zero, i_overflow, i_mul_zero, i_one_case;
  riscv_md_special_detect #(.XLEN(XLEN)) u_detect_in (
    .op       (MD_op),
    .rs1      (MD_rs1_data),
    .rs2      (MD_rs2_data),
    .div_zero (i_div_zero),
    .overflow (i_overflow),
    .mul_zero (i_mul_zero),
    .one_case (i_one_case)
  );
  assign fast_in = i_div_zero || i_overflow || i_mul_zero || i_one_case;
`else
  assign fast_in = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !fast_in) state_nxt = ST_CALC;
      ST_CALC: if (last_step) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (MD_flush) state_nxt = ST_IDLE;
  end

  // Multiply: right-shifting product, multiplier bits consumed LSB first.
  logic [XLEN:0]     add_hi;
  logic [2*XLEN-1:0] mul_next;
  assign add_hi   = {1'b0, acc[2*XLEN-1:XLEN]} + (mag_b[cnt] ? {1'b0, mag_a} : '0);
  assign mul_next = {add_hi, acc[XLEN-1:1]};

  // Divide: remainder in the upper half, quotient shifts in at the bottom,
  // dividend bits consumed MSB first.
  logic [CW-1:0]     rev_idx;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic              rem_ge;
  logic [2*XLEN-1:0] div_next;
  assign rev_idx  = CW'(XLEN - 1) - cnt;
  assign rem_sh   = {acc[2*XLEN-1:XLEN], mag_a[rev_idx]};
  assign rem_ge   = (rem_sh >= {1'b0, mag_b});
  assign rem_sub  = rem_sh[XLEN-1:0] - mag_b;
  assign div_next = {(rem_ge ? rem_sub : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  assign prod_s = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_s  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_s  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = rem_s;
    case (op_q)
      MD_MUL:                        fix_res = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_res = quo_s;
      default:                       fix_res = rem_s;
    endcase
    // op_q[1] separates REM/REMU from DIV/DIVU.
    if (q_div_zero)      fix_res = op_q[1] ? rs1_q : '1;
    else if (q_overflow) fix_res = op_q[1] ? '0 : rs1_q;
    else if (q_mul_zero) fix_res = '0;
    else if (q_one_case) fix_res = (op_q == MD_REMU) ? '0 : rs1_q;
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      fast_pend <= 1'b0;
      MD_done   <= 1'b0;
      MD_result <= '0;
    end else begin
      state     <= state_nxt;
      MD_done   <= 1'b0;
      fast_pend <= 1'b0;
      if (!MD_flush) begin
        if (fast_pend) begin
          MD_result <= fix_res;
          MD_done   <= 1'b1;
        end
        case (state)
          ST_IDLE: if (accept) begin
            op_q      <= MD_op;
            rs1_q     <= MD_rs1_data;
            rs2_q     <= MD_rs2_data;
            sign_a    <= in_sa;
            sign_b    <= in_sb;
            mag_a     <= in_mag_a;
            mag_b     <= in_mag_b;
            acc       <= '0;
            cnt       <= '0;
            fast_pend <= fast_in;
          end
          ST_CALC: begin
            acc <= op_q[2] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
          end
          ST_FIX: begin
            MD_result <= fix_res;
            MD_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
